// File: rtl/load_align_if.sv
// Load-align bus bundle: CPU-side load request plus the data-memory read port.
//   LOAD_REQ/LOAD_SEL/ADDR      load request from the pipeline
//   MEM_READ/MEM_ADDR           word read strobe and word-aligned address
//   MEM_DATA_IN/MEM_BUSYWAIT    read word and memory stall
//   DATA_OUT/DATA_VALID         extended result and its one-cycle qualifier
//   MISALIGN_ERR/BUSY           rejected-misaligned flag and stall-the-pipe flag
interface load_align_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  LOAD_REQ;
  logic [2:0]            LOAD_SEL;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic                  MEM_READ;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [31:0]           MEM_DATA_IN;
  logic                  MEM_BUSYWAIT;
  logic [31:0]           DATA_OUT;
  logic                  DATA_VALID;
  logic                  MISALIGN_ERR;
  logic                  BUSY;

  // Load unit side
  modport slave (
    input  LOAD_REQ, LOAD_SEL, ADDR, MEM_DATA_IN, MEM_BUSYWAIT,
    output MEM_READ, MEM_ADDR, DATA_OUT, DATA_VALID, MISALIGN_ERR, BUSY
  );

  // Pipeline / memory side
  modport master (
    output LOAD_REQ, LOAD_SEL, ADDR, MEM_DATA_IN, MEM_BUSYWAIT,
    input  MEM_READ, MEM_ADDR, DATA_OUT, DATA_VALID, MISALIGN_ERR, BUSY
  );
endinterface

// File: rtl/load_align_unit.sv
// Load alignment unit: turns a byte-addressed LB/LH/LW/LBU/LHU request into one
// or two word reads, extracts the addressed bytes and sign/zero-extends them.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    load_align_if.slave (request, memory read port, result, status)
// Parameters:
//   ADDR_WIDTH      byte-address width
//   MISALIGN_SPLIT  1: word-crossing loads use two reads; 0: misaligned loads
//                   are rejected with MISALIGN_ERR
module load_align_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  load_align_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD0  = 2'd1,
    S_RD1  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [2:0]            r_sel;
  logic [1:0]            r_off;
  logic                  r_cross;
  logic [31:0]           r_word0;
  logic                  r_mem_read;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_data_out;
  logic                  r_data_valid;
  logic                  r_misalign_err;
  logic                  r_busy;

  logic                  w_sel_valid;
  logic                  w_misaligned;
  logic                  w_crossing;
  logic [63:0]           w_pair;
  logic [31:0]           w_shifted;
  logic [31:0]           w_result;

  // Classify the incoming request from LOAD_SEL and the low address bits
  always_comb begin
    w_sel_valid  = 1'b0;
    w_misaligned = 1'b0;
    w_crossing   = 1'b0;
    case (bus.LOAD_SEL)
      3'b000, 3'b100: w_sel_valid = 1'b1;
      3'b001, 3'b101: begin
        w_sel_valid  = 1'b1;
        w_misaligned = bus.ADDR[0];
        w_crossing   = (bus.ADDR[1:0] == 2'b11);
      end
      3'b010: begin
        w_sel_valid  = 1'b1;
        w_misaligned = (bus.ADDR[1:0] != 2'b00);
        w_crossing   = (bus.ADDR[1:0] != 2'b00);
      end
      default: w_sel_valid = 1'b0;
    endcase
  end

  // In RD1 the result spans {word1, word0}; in RD0 only the current word matters
  assign w_pair    = (r_state == S_RD1) ? {bus.MEM_DATA_IN, r_word0}
                                        : {32'h0, bus.MEM_DATA_IN};
  assign w_shifted = 32'(w_pair >> {r_off, 3'b000});

  // Size select from r_sel[1:0], zero-extend when r_sel[2] is set
  always_comb begin
    w_result = w_shifted;
    case (r_sel[1:0])
      2'b00:   w_result = r_sel[2] ? {24'h0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_result = r_sel[2] ? {16'h0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_result = w_shifted;
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state        <= S_IDLE;
      r_sel          <= 3'b000;
      r_off          <= 2'b00;
      r_cross        <= 1'b0;
      r_word0        <= 32'h0;
      r_mem_read     <= 1'b0;
      r_mem_addr     <= '0;
      r_data_out     <= 32'h0;
      r_data_valid   <= 1'b0;
      r_misalign_err <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.LOAD_REQ) begin
            r_sel   <= bus.LOAD_SEL;
            r_off   <= bus.ADDR[1:0];
            r_cross <= w_crossing && MISALIGN_SPLIT;
            r_busy  <= 1'b1;
            if (!w_sel_valid) begin
              r_state        <= S_DONE;
              r_data_out     <= 32'h0;
              r_data_valid   <= 1'b1;
              r_misalign_err <= 1'b0;
            end else if (w_misaligned && !MISALIGN_SPLIT) begin
              r_state        <= S_DONE;
              r_data_out     <= 32'h0;
              r_data_valid   <= 1'b1;
              r_misalign_err <= 1'b1;
            end else begin
              r_state    <= S_RD0;
              r_mem_read <= 1'b1;
              r_mem_addr <= {bus.ADDR[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        end
        S_RD0: begin
          if (!bus.MEM_BUSYWAIT) begin
            if (r_cross) begin
              // Keep the read strobe up and step to the next word
              r_word0    <= bus.MEM_DATA_IN;
              r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
              r_state    <= S_RD1;
            end else begin
              r_mem_read   <= 1'b0;
              r_mem_addr   <= '0;
              r_data_out   <= w_result;
              r_data_valid <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_RD1: begin
          if (!bus.MEM_BUSYWAIT) begin
            r_mem_read   <= 1'b0;
            r_mem_addr   <= '0;
            r_data_out   <= w_result;
            r_data_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_data_valid   <= 1'b0;
          r_misalign_err <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.MEM_READ     = r_mem_read;
  assign bus.MEM_ADDR     = r_mem_addr;
  assign bus.DATA_OUT     = r_data_out;
  assign bus.DATA_VALID   = r_data_valid;
  assign bus.MISALIGN_ERR = r_misalign_err;
  assign bus.BUSY         = r_busy;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: one instance with split reads, one rejecting
// misaligned loads, both fed by a small word-memory model with programmable stalls.
module tb_load_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_s;
  logic        req_n;
  logic [2:0]  sel;
  logic [31:0] addr;
  int unsigned waits_cfg;
  int unsigned stall_s;
  int unsigned stall_n;
  int          n_tests;
  int          n_fail;

  load_align_if #(.ADDR_WIDTH(32)) bs ();
  load_align_if #(.ADDR_WIDTH(32)) bn ();

  load_align_unit #(.ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1)) u_split (
    .CLK(clk), .RESET(rst_n), .bus(bs)
  );
  load_align_unit #(.ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b0)) u_nosplit (
    .CLK(clk), .RESET(rst_n), .bus(bn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h8877_6655;
      32'h0000_0104: mem_word = 32'hCCBB_AA99;
      32'hFFFF_FFFC: mem_word = 32'h4433_2211;
      32'h0000_0000: mem_word = 32'h0102_0304;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bs.LOAD_REQ     = req_s;
  assign bs.LOAD_SEL     = sel;
  assign bs.ADDR         = addr;
  assign bs.MEM_DATA_IN  = mem_word(bs.MEM_ADDR);
  assign bs.MEM_BUSYWAIT = bs.MEM_READ && (stall_s < waits_cfg);
  assign bn.LOAD_REQ     = req_n;
  assign bn.LOAD_SEL     = sel;
  assign bn.ADDR         = addr;
  assign bn.MEM_DATA_IN  = mem_word(bn.MEM_ADDR);
  assign bn.MEM_BUSYWAIT = bn.MEM_READ && (stall_n < waits_cfg);

  // Stall budget is spent per load, starting from the first read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_s <= 0;
    else if (!bs.BUSY)                       stall_s <= 0;
    else if (bs.MEM_READ && bs.MEM_BUSYWAIT) stall_s <= stall_s + 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_n <= 0;
    else if (!bn.BUSY)                       stall_n <= 0;
    else if (bn.MEM_READ && bn.MEM_BUSYWAIT) stall_n <= stall_n + 1;
  end

  // Snapshot of both instances (index 0 = split, 1 = no-split)
  logic        s_rd [2];
  logic        s_bw [2];
  logic        s_dv [2];
  logic        s_er [2];
  logic        s_by [2];
  logic [31:0] s_ma [2];
  logic [31:0] s_dq [2];

  task automatic sample();
    s_rd[0] = bs.MEM_READ;   s_rd[1] = bn.MEM_READ;
    s_bw[0] = bs.MEM_BUSYWAIT; s_bw[1] = bn.MEM_BUSYWAIT;
    s_dv[0] = bs.DATA_VALID; s_dv[1] = bn.DATA_VALID;
    s_er[0] = bs.MISALIGN_ERR; s_er[1] = bn.MISALIGN_ERR;
    s_by[0] = bs.BUSY;       s_by[1] = bn.BUSY;
    s_ma[0] = bs.MEM_ADDR;   s_ma[1] = bn.MEM_ADDR;
    s_dq[0] = bs.DATA_OUT;   s_dq[1] = bn.DATA_OUT;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    int          waits;
    logic [31:0] data;   // expected result with split reads
    int          lat;    // cycles from accept edge to DATA_VALID
    int          nreads; // completed word reads
    logic        err_n;  // rejected by the no-split instance
    logic [31:0] ra0;
    logic [31:0] ra1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(input logic [2:0] s, input logic [31:0] a, input int w,
                               input logic [31:0] d, input int l, input int nr,
                               input logic e, input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.sel = s; v.addr = a; v.waits = w; v.data = d; v.lat = l;
    v.nreads = nr; v.err_n = e; v.ra0 = r0; v.ra1 = r1;
    return v;
  endfunction

  // Issue one load to both instances and compare what each one does
  task automatic run_vec(input int idx, input vec_t v);
    int          lat [2];
    int          nr  [2];
    logic [31:0] dat [2];
    logic        err [2];
    logic [31:0] ra  [2][2];
    logic        inv [2];
    logic        done;
    int          e_lat;
    int          e_nr;
    logic [31:0] e_dat;
    logic        e_err;
    string       nm;
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; nr[i] = 0; dat[i] = 32'h0; err[i] = 1'b0; inv[i] = 1'b0;
      ra[i][0] = 32'h0; ra[i][1] = 32'h0;
    end
    done = 1'b0;
    waits_cfg = v.waits;
    @(negedge clk);
    req_s = 1'b1; req_n = 1'b1; sel = v.sel; addr = v.addr;
    @(negedge clk);
    req_s = 1'b0; req_n = 1'b0;
    for (int k = 1; k <= 25 && !done; k++) begin
      if (k > 1) @(negedge clk);
      sample();
      for (int i = 0; i < 2; i++) begin
        if (s_rd[i] && !s_bw[i]) begin
          if (nr[i] < 2) ra[i][nr[i]] = s_ma[i];
          nr[i]++;
        end
        if (s_rd[i] && (s_ma[i][1:0] != 2'b00)) inv[i] = 1'b1;
        if (s_er[i] && !s_dv[i]) inv[i] = 1'b1;
        if (s_rd[i] && s_dv[i]) inv[i] = 1'b1;
        if (s_dv[i]) begin
          if (lat[i] != 0) inv[i] = 1'b1;
          else begin lat[i] = k; dat[i] = s_dq[i]; err[i] = s_er[i]; end
        end
      end
      done = (lat[0] != 0) && (lat[1] != 0) && !s_by[0] && !s_by[1];
    end
    check($sformatf("v%0d timeout", idx), 32'(done), 32'd1);
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "split" : "nosplit";
      if (i == 1 && v.err_n) begin
        e_lat = 1; e_nr = 0; e_dat = 32'h0; e_err = 1'b1;
      end else begin
        e_lat = v.lat; e_nr = v.nreads; e_dat = v.data; e_err = 1'b0;
      end
      check($sformatf("v%0d %s latency", idx, nm), 32'(lat[i]), 32'(e_lat));
      check($sformatf("v%0d %s data", idx, nm), dat[i], e_dat);
      check($sformatf("v%0d %s err", idx, nm), 32'(err[i]), 32'(e_err));
      check($sformatf("v%0d %s reads", idx, nm), 32'(nr[i]), 32'(e_nr));
      check($sformatf("v%0d %s invariants", idx, nm), 32'(inv[i]), 32'd0);
      check($sformatf("v%0d %s hold", idx, nm), s_dq[i], e_dat);
      if (e_nr >= 1) check($sformatf("v%0d %s addr0", idx, nm), ra[i][0], v.ra0);
      if (e_nr >= 2) check($sformatf("v%0d %s addr1", idx, nm), ra[i][1], v.ra1);
    end
  endtask

  initial begin
    logic flag;
    n_tests = 0; n_fail = 0;
    req_s = 1'b0; req_n = 1'b0; sel = 3'b000; addr = 32'h0; waits_cfg = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    // Reset values before any clock edge
    sample();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset flags %0d", i), {28'h0, s_rd[i], s_dv[i], s_er[i], s_by[i]}, 32'h0);
      check($sformatf("reset mem_addr %0d", i), s_ma[i], 32'h0);
      check($sformatf("reset data_out %0d", i), s_dq[i], 32'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    vq.push_back(mkv(3'b000, 32'h0000_0103, 0, 32'hFFFF_FF88, 2, 1, 1'b0, 32'h100, 32'h0));
    vq.push_back(mkv(3'b101, 32'h0000_0102, 0, 32'h0000_8877, 2, 1, 1'b0, 32'h100, 32'h0));
    vq.push_back(mkv(3'b001, 32'h0000_0103, 0, 32'hFFFF_9988, 3, 2, 1'b1, 32'h100, 32'h104));
    vq.push_back(mkv(3'b010, 32'h0000_0102, 0, 32'hAA99_8877, 3, 2, 1'b1, 32'h100, 32'h104));
    vq.push_back(mkv(3'b001, 32'h0000_0101, 0, 32'h0000_7766, 2, 1, 1'b1, 32'h100, 32'h0));
    vq.push_back(mkv(3'b010, 32'h0000_0100, 3, 32'h8877_6655, 5, 1, 1'b0, 32'h100, 32'h0));
    vq.push_back(mkv(3'b011, 32'h0000_0100, 0, 32'h0000_0000, 1, 0, 1'b0, 32'h0,   32'h0));
    vq.push_back(mkv(3'b100, 32'h0000_0101, 0, 32'h0000_0066, 2, 1, 1'b0, 32'h100, 32'h0));
    vq.push_back(mkv(3'b000, 32'h0000_0100, 0, 32'h0000_0055, 2, 1, 1'b0, 32'h100, 32'h0));
    vq.push_back(mkv(3'b000, 32'h0000_0104, 0, 32'hFFFF_FF99, 2, 1, 1'b0, 32'h104, 32'h0));
    vq.push_back(mkv(3'b101, 32'h0000_0106, 0, 32'h0000_CCBB, 2, 1, 1'b0, 32'h104, 32'h0));
    vq.push_back(mkv(3'b010, 32'hFFFF_FFFE, 0, 32'h0304_4433, 3, 2, 1'b1, 32'hFFFF_FFFC, 32'h0));
    vq.push_back(mkv(3'b001, 32'h0000_0103, 2, 32'hFFFF_9988, 5, 2, 1'b1, 32'h100, 32'h104));
    vq.push_back(mkv(3'b111, 32'h0000_0104, 0, 32'h0000_0000, 1, 0, 1'b0, 32'h0,   32'h0));
    vq.push_back(mkv(3'b101, 32'h0000_0103, 0, 32'h0000_9988, 3, 2, 1'b1, 32'h100, 32'h104));
    vq.push_back(mkv(3'b001, 32'h0000_0106, 2, 32'hFFFF_CCBB, 4, 1, 1'b0, 32'h104, 32'h0));
    vq.push_back(mkv(3'b110, 32'h0000_0100, 0, 32'h0000_0000, 1, 0, 1'b0, 32'h0,   32'h0));
    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // Reset while stalled in RD0: read strobe drops at once, load is abandoned
    waits_cfg = 10;
    @(negedge clk);
    req_s = 1'b1; req_n = 1'b1; sel = 3'b010; addr = 32'h100;
    @(negedge clk);
    req_s = 1'b0; req_n = 1'b0;
    @(negedge clk);
    sample();
    check("rd0 stalled split", {31'h0, s_rd[0]}, 32'd1);
    check("rd0 stalled nosplit", {31'h0, s_rd[1]}, 32'd1);
    #2 rst_n = 1'b0;
    #1 sample();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort flags %0d", i), {28'h0, s_rd[i], s_dv[i], s_er[i], s_by[i]}, 32'h0);
      check($sformatf("abort mem_addr %0d", i), s_ma[i], 32'h0);
      check($sformatf("abort data_out %0d", i), s_dq[i], 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    waits_cfg = 0;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sample();
      if (s_dv[0] || s_dv[1] || s_by[0] || s_by[1] || s_rd[0] || s_rd[1]) flag = 1'b1;
    end
    check("no activity after abort", {31'h0, flag}, 32'd0);
    run_vec(100, vq[0]);

    // Requests held during BUSY are dropped (split instance only)
    @(negedge clk);
    req_s = 1'b1; sel = 3'b010; addr = 32'h102;
    flag = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      sample();
      if (!s_by[0]) flag = 1'b1;
      if (k == 3) begin
        check("busy lw dv", {31'h0, s_dv[0]}, 32'd1);
        check("busy lw data", s_dq[0], 32'hAA99_8877);
        req_s = 1'b0;
      end else begin
        sel = 3'b000; addr = 32'h100;
      end
    end
    check("busy high T+1..T+3", {31'h0, flag}, 32'd0);
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      sample();
      if (s_by[0] || s_rd[0] || s_dv[0]) flag = 1'b1;
    end
    check("held request ignored", {31'h0, flag}, 32'd0);
    check("data held after load", s_dq[0], 32'hAA99_8877);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, giving the byte-address width.
REQ-002 The module SHALL have parameter MISALIGN_SPLIT, default 1: 1 = split word-crossing loads into two reads; 0 = flag misaligned loads as errors.
REQ-003 The clock port SHALL be CLK  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 The reset port SHALL be RESET  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have LOAD_REQ  input  1  load request; sampled only while BUSY=0.
REQ-006 The module SHALL have LOAD_SEL  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are invalid.
REQ-007 The module SHALL have ADDR  input  ADDR_WIDTH  byte address of the load.
REQ-008 The module SHALL have MEM_READ  output  1  word read strobe to data memory.
REQ-009 The module SHALL have MEM_ADDR  output  ADDR_WIDTH  word-aligned read address; bits [1:0] are always 0.
REQ-010 The module SHALL have MEM_DATA_IN  input  32  read word; byte lane k = bits [8k+7:8k], little-endian.
REQ-011 The module SHALL have MEM_BUSYWAIT  input  1  memory stall; read data is valid in a cycle with MEM_READ=1 and MEM_BUSYWAIT=0.
REQ-012 The module SHALL have DATA_OUT  output  32  extended load result, registered.
REQ-013 The module SHALL have DATA_VALID  output  1  one-cycle pulse qualifying DATA_OUT and MISALIGN_ERR.
REQ-014 The module SHALL have MISALIGN_ERR  output  1  misaligned load rejected; MISALIGN_SPLIT=0 only.
REQ-015 The module SHALL have BUSY  output  1  high whenever the state is not IDLE; used for pipeline stall.

Function
REQ-016 FSM states SHALL be IDLE, RD0, RD1, DONE.
REQ-017 In IDLE with LOAD_REQ=1, the module SHALL capture ADDR and LOAD_SEL, then go to RD0; on the error or invalid paths it SHALL go to DONE instead.
REQ-018 Offset SHALL be ADDR[1:0]. Misaligned means LH/LHU with odd offset, or LW with offset != 0. Crossing means LH/LHU at offset 3, or LW at offset != 0.
REQ-019 With MISALIGN_SPLIT=0, a misaligned request SHALL go directly to DONE with MISALIGN_ERR=1, DATA_OUT=0 and no memory read.
REQ-020 An invalid LOAD_SEL SHALL go directly to DONE with DATA_OUT=0, MISALIGN_ERR=0 and no memory read.
REQ-021 In RD0, MEM_READ SHALL be 1 and MEM_ADDR SHALL be {addr[AW-1:2],2'b00}. The state SHALL hold while MEM_BUSYWAIT=1. Otherwise it SHALL capture word0 and go to RD1 if crossing and MISALIGN_SPLIT=1, else to DONE.
REQ-022 In RD1, MEM_READ SHALL be 1 and MEM_ADDR SHALL be word0 address + 4, wrapping modulo 2^ADDR_WIDTH. The state SHALL hold while MEM_BUSYWAIT=1, else capture word1 and go to DONE.
REQ-023 Result bytes SHALL be taken from the 64-bit value {word1,word0} starting at byte offset. Byte/half results SHALL be sign-extended for LB/LH and zero-extended for LBU/LHU. LW SHALL use 4 bytes.
REQ-024 In DONE, DATA_VALID SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE. A new request SHALL be accepted no earlier than the following IDLE cycle.
REQ-025 Latency with zero wait states, request accepted at edge T: DATA_VALID SHALL be high in cycle T+2 for a single read and T+3 for a split read. Each MEM_BUSYWAIT cycle SHALL add one cycle.
REQ-026 LOAD_REQ while BUSY=1 SHALL be ignored and not queued.
REQ-027 MEM_READ SHALL be 0 in IDLE and DONE.
REQ-028 DATA_OUT SHALL hold its last value until the next DONE.
REQ-029 MISALIGN_ERR SHALL be 0 outside DONE.

Reset
REQ-030 While RESET=0, state SHALL be IDLE and MEM_READ, MEM_ADDR, DATA_OUT, DATA_VALID, MISALIGN_ERR and BUSY SHALL all be 0, independent of CLK.
REQ-031 Reset asserted in RD0 or RD1 SHALL drop MEM_READ immediately, abandon the load and produce no DATA_VALID.
REQ-032 After release, the first rising edge with LOAD_REQ=1 SHALL be accepted.

Verification
Memory preload: word 0x100 = 0x88776655; word 0x104 = 0xCCBBAA99.
REQ-033 LB at 0x103, no waits -> one read of 0x100; DATA_VALID at T+2; DATA_OUT=0xFFFFFF88.
REQ-034 LHU at 0x102 -> DATA_OUT=0x00008877; LH at 0x103 (split) -> reads 0x100 then 0x104; DATA_OUT=0xFFFF9988 at T+3.
REQ-035 LW at 0x102, MISALIGN_SPLIT=1 -> reads 0x100 then 0x104; DATA_OUT=0xAA998877; BUSY high T+1..T+3.
REQ-036 MISALIGN_SPLIT=0, LH at 0x101 -> MEM_READ never high; DATA_VALID and MISALIGN_ERR high at T+1; DATA_OUT=0.
REQ-037 LW at 0x100 with 3 MEM_BUSYWAIT cycles -> MEM_ADDR=0x100 held; DATA_OUT=0x88776655 at T+5. Repeat with RESET=0 during RD0 -> MEM_READ=0 immediately, no DATA_VALID.
REQ-038 LOAD_SEL=011 -> no read; DATA_VALID at T+1 with DATA_OUT=0. A second LOAD_REQ during BUSY -> ignored.
